// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring, one quotient bit per clock,
// with sign pre/post-correction and RISC-V divide-by-zero / signed-overflow handling.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q, neg_r;
  logic [1:0]       op_q;

  logic             signed_op, div_zero, ovf;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    signed_op = ~op[0];
    a_abs     = (signed_op && A[WIDTH-1]) ? -A : A;
    b_abs     = (signed_op && B[WIDTH-1]) ? -B : B;
    div_zero  = (B == '0);
    ovf       = signed_op && (A == MIN_NEG) && (B == '1);
    shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (div_zero || ovf) ? FINISH : CALC;
      CALC:    if (count == CW'(WIDTH-1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      op_q   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: if (start) begin
            op_q  <= op;
            count <= '0;
            // Special cases preload quo/rem with the final answer and clear the sign
            // flags, so FINISH handles them exactly like a completed iteration.
            if (div_zero) begin
              quo   <= '1;
              rem   <= {1'b0, A};
              dvs   <= B;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (ovf) begin
              quo   <= MIN_NEG;
              rem   <= '0;
              dvs   <= B;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= a_abs;
              rem   <= '0;
              dvs   <= b_abs;
              neg_q <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_r <= signed_op && A[WIDTH-1];
            end
          end
          CALC: begin
            count <= count + 1'b1;
            if (!diff[WIDTH]) begin
              rem <= diff;
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted;
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end
          FINISH: begin
            if (op_q[1]) result <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            else         result <= neg_q ? -quo : quo;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M division unit: computes DIV, DIVU, REM and REMU on 32-bit operands with a start/done handshake. It is the multi-cycle responder beside the single-cycle `alu` in the execute stage. Execute issues an operation with `start`, holds the pipeline while `busy` is high, and takes `result` when `done` pulses. The core is a radix-2 restoring divider, one quotient bit per clock, with sign pre- and post-correction and RISC-V special-case handling.

## Interface
- WIDTH, 32: operand and result width; iteration count equals WIDTH
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; the clock and reset are the block's only clock/reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous kill of any in-flight operation
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with start
- A  input  WIDTH  dividend; captured with start
- B  input  WIDTH  divisor; captured with start
- result  output  WIDTH  quotient or remainder of last completed op; held until next completion
- busy  output  1  high while an accepted op is in flight
- done  output  1  one-cycle pulse: result valid this cycle

## Operation
- Reset (reset=0, async): state IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 and flush=0: capture op, A, B.
  - Signed ops (DIV, REM): store |A| and |B|, plus sign flags neg_q = A[31]^B[31] and neg_r = A[31].
  - Go to CALC with counter=0, or go straight to FINISH on a special case.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by one.
  - Trial subtract divisor from rem. If non-negative, keep the difference and set quo[0]=1.
  - counter increments. At the edge where counter==WIDTH-1 completes, go to FINISH.
- FINISH, one edge:
  - Quotient ops write quo into result, negated if neg_q.
  - Remainder ops write rem into result, negated if neg_r.
  - done=1 for the following cycle; go to IDLE.
- Special cases, detected at accept and skipping CALC:
  - B==0: quotient result = all ones; remainder result = A unmodified.
  - Signed overflow, DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Operands and op are frozen at accept. Input changes while busy are ignored.
- start while busy is ignored and not queued.
- flush=1 in any state: next edge goes to IDLE, busy=0, done=0, result unchanged.
  - flush with start in IDLE: flush wins and start is dropped.
  - flush in FINISH: no done pulse, result not written.
- Arithmetic: remainder register is WIDTH+1 bits so the trial subtract produces a borrow. Negation is two's complement modulo 2^WIDTH.

## Timing
- Start accepted at edge N. busy=1 from after edge N until after the edge that raises done; busy=0 in the done cycle.
- Normal op: CALC occupies edges N+1..N+WIDTH. FINISH executes at edge N+WIDTH+1, so done=1 in the cycle after edge N+33 (WIDTH=32).
- Special case: FINISH executes at edge N+1, so done=1 in the cycle after edge N+1.
- done is high for exactly one cycle. result is registered and stable from the done cycle until the next FINISH.
- Back-to-back: start may be asserted during the done cycle. It is accepted at that cycle's closing edge because the state is already IDLE.
- Reset mid-operation clears everything immediately (asynchronous). The first start after release is accepted on the first edge with reset=1.

## Test plan
- DIVU A=100, B=7, start at edge N -> done in the cycle after edge N+33, result=14. Repeat with REMU -> result=2. busy high for exactly 33 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> result=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIV A=7, B=0xFFFFFFFE -> 0xFFFFFFFD.
- Divide by zero: DIVU A=5, B=0 -> done after edge N+1, result=0xFFFFFFFF. REMU A=5, B=0 -> result=5. DIV A=0x80000000, B=0 -> 0xFFFFFFFF.
- Overflow: DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000. REM same operands -> 0. Both take the 1-edge latency.
- Control, first half: start DIVU 100/7, then re-assert start with A=1, B=1 at edge N+5 -> ignored, result still 14.
- Control, second half: start again, assert flush at edge N+10 -> busy=0 next cycle, no done, result stays 14. Immediate new start DIVU 9/3 -> result=3.
- Reset: drop reset at edge N+20 of an active op -> busy=0, done=0, result=0 asynchronously. After release, DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
